// File: rtl/note_sprite_renderer.sv
// rtl/note_sprite_renderer.sv - per-frame sprite snapshot and 2-stage scaled pixel lookup
module note_sprite_renderer #(
    parameter int SCALE_LOG2 = 2,
    parameter int H_W        = 11,
    parameter int V_W        = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [H_W-1:0]      h_count_in,
    input  logic [V_W-1:0]      v_count_in,
    input  logic                active_draw_in,
    input  logic                new_frame_in,
    input  logic [47:0]         note_sprite_in [0:15],
    input  logic [H_W-1:0]      x_in,
    input  logic [V_W-1:0]      y_in,
    input  logic [23:0]         color_in,
    input  logic                enable_in,
    output logic [23:0]         pixel_out,
    output logic                sprite_hit_out,
    output logic                active_draw_out
);

    // Scaled sprite box extent, one bit wider than the counters so the
    // signed offsets compare without overflow.
    localparam logic [H_W:0] BOX_W = (H_W+1)'(48 << SCALE_LOG2);
    localparam logic [V_W:0] BOX_H = (V_W+1)'(16 << SCALE_LOG2);

    // Shadow copy of the producer state, refreshed only on new_frame_in
    logic [47:0]    sh_rows [0:15];
    logic [H_W-1:0] sh_x;
    logic [V_W-1:0] sh_y;
    logic [23:0]    sh_color;
    logic           sh_enable;

    // Stage 1 registers. The row word and colour are captured here so a
    // pixel always finishes with the shadow it started with.
    logic           s1_in_box;
    logic [5:0]     s1_col;
    logic [47:0]    s1_row;
    logic [23:0]    s1_color;
    logic           s1_active;

    logic [H_W:0]   dx_c;
    logic [V_W:0]   dy_c;
    logic           in_box_c;
    logic [3:0]     row_idx_c;
    logic [5:0]     col_c;
    logic [5:0]     base_c;
    logic [5:0]     bit_idx_c;
    logic           hit_c;

    // Snapshot the producer state at frame start; reset wins over a snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                sh_rows[i] <= '0;
            end
            sh_x      <= '0;
            sh_y      <= '0;
            sh_color  <= '0;
            sh_enable <= 1'b0;
        end else if (new_frame_in) begin
            for (int i = 0; i < 16; i++) begin
                sh_rows[i] <= note_sprite_in[i];
            end
            sh_x      <= x_in;
            sh_y      <= y_in;
            sh_color  <= color_in;
            sh_enable <= enable_in;
        end
    end

    // Stage 1 combinational: box offsets, containment test, sprite coordinates
    always_comb begin
        dx_c      = {1'b0, h_count_in} - {1'b0, sh_x};
        dy_c      = {1'b0, v_count_in} - {1'b0, sh_y};
        in_box_c  = !dx_c[H_W] && (dx_c < BOX_W) &&
                    !dy_c[V_W] && (dy_c < BOX_H) &&
                    active_draw_in && sh_enable;
        row_idx_c = 4'(dy_c >> SCALE_LOG2);
        col_c     = 6'(dx_c >> SCALE_LOG2);
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_in_box <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_color  <= '0;
            s1_active <= 1'b0;
        end else begin
            s1_in_box <= in_box_c;
            s1_col    <= col_c;
            s1_row    <= sh_rows[row_idx_c];
            s1_color  <= sh_color;
            s1_active <= active_draw_in;
        end
    end

    // Stage 2 combinational: screen order is letter, accidental, octave,
    // each glyph drawn MSB-first from its left edge
    always_comb begin
        case (s1_col[5:4])
            2'd0:    base_c = 6'd16;
            2'd1:    base_c = 6'd0;
            2'd2:    base_c = 6'd32;
            default: base_c = 6'd0;
        endcase
        bit_idx_c = base_c + (6'd15 - {2'b00, s1_col[3:0]});
        hit_c     = s1_in_box && s1_row[bit_idx_c];
    end

    // Stage 2 register: output pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out       <= '0;
            sprite_hit_out  <= 1'b0;
            active_draw_out <= 1'b0;
        end else begin
            pixel_out       <= hit_c ? s1_color : 24'h0;
            sprite_hit_out  <= hit_c;
            active_draw_out <= s1_active;
        end
    end

endmodule

// File: tb/tb_note_sprite_renderer.sv
// tb/tb_note_sprite_renderer.sv - directed vector bench for note_sprite_renderer
module tb_note_sprite_renderer;

    localparam logic [23:0] COL = 24'hFF8000;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count_in;
    logic [9:0]  v_count_in;
    logic        active_draw_in;
    logic        new_frame_in;
    logic [47:0] note_sprite_in [0:15];
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [23:0] color_in;
    logic        enable_in;
    logic [23:0] pixel_out;
    logic        sprite_hit_out;
    logic        active_draw_out;

    int n_cmp = 0;
    int n_err = 0;

    note_sprite_renderer #(.SCALE_LOG2(2), .H_W(11), .V_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .h_count_in      (h_count_in),
        .v_count_in      (v_count_in),
        .active_draw_in  (active_draw_in),
        .new_frame_in    (new_frame_in),
        .note_sprite_in  (note_sprite_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .color_in        (color_in),
        .enable_in       (enable_in),
        .pixel_out       (pixel_out),
        .sprite_hit_out  (sprite_hit_out),
        .active_draw_out (active_draw_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          setup;
        logic [10:0] h;
        logic [9:0]  v;
        logic        ad;
        logic [23:0] pix;
        logic        hit;
    } vec_t;

    vec_t vecs [0:33];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [23:0] pix, input logic hit, input logic ad);
        chk({name, ".pixel"}, pixel_out, pix);
        chk({name, ".hit"}, {23'd0, sprite_hit_out}, {23'd0, hit});
        chk({name, ".ad"}, {23'd0, active_draw_out}, {23'd0, ad});
    endtask

    task automatic set_rows(input int setup);
        for (int i = 0; i < 16; i++) note_sprite_in[i] = 48'h0;
        case (setup)
            0: note_sprite_in[0] = 48'h0000_8000_0000;
            1: note_sprite_in[0] = 48'h0000_0000_8000;
            2: note_sprite_in[0] = 48'h8000_0000_0000;
            3: note_sprite_in[0] = 48'h0001_0000_0000;
            4: for (int i = 0; i < 16; i++) note_sprite_in[i] = 48'hFFFF_FFFF_FFFF;
            5: note_sprite_in[15] = 48'h0000_8000_0000;
            default: ;
        endcase
    endtask

    task automatic snapshot(input int setup, input logic [10:0] x, input logic [9:0] y);
        @(negedge clk);
        set_rows(setup);
        x_in = x; y_in = y; color_in = COL; enable_in = 1'b1;
        active_draw_in = 1'b0;
        new_frame_in = 1'b1;
        @(negedge clk);
        new_frame_in = 1'b0;
    endtask

    task automatic run_pixel(input string name, input logic [10:0] h, input logic [9:0] v,
                             input logic ad, input logic [23:0] pix, input logic hit);
        @(negedge clk);
        h_count_in = h; v_count_in = v; active_draw_in = ad;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_out(name, pix, hit, ad);
    endtask

    initial begin
        int cur;
        vecs[0]  = '{0, 100, 50, 1, COL, 1};
        vecs[1]  = '{0, 103, 53, 1, COL, 1};
        vecs[2]  = '{0, 101, 52, 1, COL, 1};
        vecs[3]  = '{0, 104, 50, 1, 24'h0, 0};
        vecs[4]  = '{0, 100, 54, 1, 24'h0, 0};
        vecs[5]  = '{0,  99, 50, 1, 24'h0, 0};
        vecs[6]  = '{1, 164, 50, 1, COL, 1};
        vecs[7]  = '{1, 167, 53, 1, COL, 1};
        vecs[8]  = '{1, 163, 50, 1, 24'h0, 0};
        vecs[9]  = '{1, 168, 50, 1, 24'h0, 0};
        vecs[10] = '{2, 228, 50, 1, COL, 1};
        vecs[11] = '{2, 231, 53, 1, COL, 1};
        vecs[12] = '{2, 232, 50, 1, 24'h0, 0};
        vecs[13] = '{2, 100, 50, 1, 24'h0, 0};
        vecs[14] = '{3, 288, 50, 1, COL, 1};
        vecs[15] = '{3, 291, 53, 1, COL, 1};
        vecs[16] = '{3, 292, 50, 1, 24'h0, 0};
        vecs[17] = '{3, 287, 50, 1, 24'h0, 0};
        vecs[18] = '{4, 100, 50, 1, COL, 1};
        vecs[19] = '{4, 291, 113, 1, COL, 1};
        vecs[20] = '{4,  99, 50, 1, 24'h0, 0};
        vecs[21] = '{4, 292, 50, 1, 24'h0, 0};
        vecs[22] = '{4, 100, 49, 1, 24'h0, 0};
        vecs[23] = '{4, 100, 114, 1, 24'h0, 0};
        vecs[24] = '{4, 150, 80, 0, 24'h0, 0};
        vecs[25] = '{4, 200, 70, 1, COL, 1};
        vecs[26] = '{4, 2000, 70, 1, 24'h0, 0};
        vecs[27] = '{4, 200, 1000, 1, 24'h0, 0};
        vecs[28] = '{5, 100, 110, 1, COL, 1};
        vecs[29] = '{5, 103, 113, 1, COL, 1};
        vecs[30] = '{5, 100, 109, 1, 24'h0, 0};
        vecs[31] = '{5, 100, 50, 1, 24'h0, 0};
        vecs[32] = '{5, 104, 110, 1, 24'h0, 0};
        vecs[33] = '{5, 100, 114, 1, 24'h0, 0};

        // Reset with in-box stimulus and lit sprite inputs, no snapshot
        rst = 1'b1; new_frame_in = 1'b0;
        h_count_in = 100; v_count_in = 50; active_draw_in = 1'b1;
        set_rows(4); x_in = 100; y_in = 50; color_in = COL; enable_in = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_out("rst_c0", 24'h0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        chk_out("rst_c1", 24'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk({"post_rst.pixel"}, pixel_out, 24'h0);
            chk({"post_rst.hit"}, {23'd0, sprite_hit_out}, 24'h0);
        end

        // Table-driven vectors, snapshot taken whenever the setup changes
        cur = -1;
        for (int i = 0; i < 34; i++) begin
            if (vecs[i].setup != cur) begin
                cur = vecs[i].setup;
                snapshot(cur, 100, 50);
            end
            run_pixel($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].ad,
                      vecs[i].pix, vecs[i].hit);
        end

        // Exact 2-cycle latency: one in-box pixel framed by misses
        snapshot(0, 100, 50);
        @(negedge clk); h_count_in = 0; v_count_in = 0; active_draw_in = 1'b1;
        @(negedge clk); h_count_in = 100; v_count_in = 50;
        @(negedge clk); h_count_in = 0;   v_count_in = 0;
        chk_out("lat_t1", 24'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("lat_t2", COL, 1'b1, 1'b1);
        @(negedge clk);
        chk_out("lat_t3", 24'h0, 1'b0, 1'b1);

        // Anti-tearing: mid-frame producer changes ignored until next snapshot
        @(negedge clk);
        note_sprite_in[0] = 48'h0000_4000_0000; x_in = 200;
        run_pixel("tear_old_hit", 100, 50, 1, COL, 1'b1);
        run_pixel("tear_new_miss", 204, 50, 1, 24'h0, 1'b0);
        @(negedge clk); new_frame_in = 1'b1;
        @(negedge clk); new_frame_in = 1'b0;
        run_pixel("tear_after_old", 100, 50, 1, 24'h0, 1'b0);
        run_pixel("tear_after_new", 204, 50, 1, COL, 1'b1);

        // new_frame_in with an in-box pixel: that pixel uses the old shadow
        snapshot(0, 100, 50);
        @(negedge clk); h_count_in = 0; v_count_in = 0; active_draw_in = 1'b1;
        @(negedge clk);
        h_count_in = 100; v_count_in = 50;
        for (int i = 0; i < 16; i++) note_sprite_in[i] = 48'h0;
        x_in = 300; new_frame_in = 1'b1;
        @(negedge clk); new_frame_in = 1'b0;
        chk_out("sim_nf_t1", 24'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("sim_nf_old", COL, 1'b1, 1'b1);
        @(negedge clk);
        chk_out("sim_nf_new", 24'h0, 1'b0, 1'b1);

        // rst with new_frame_in: reset wins, shadow stays cleared
        snapshot(4, 100, 50);
        @(negedge clk); rst = 1'b1; new_frame_in = 1'b1; set_rows(4);
        x_in = 100; y_in = 50; enable_in = 1'b1;
        @(negedge clk); rst = 1'b0; new_frame_in = 1'b0;
        run_pixel("rst_nf", 100, 50, 1, 24'h0, 1'b0);

        // Held new_frame_in: last snapshot wins
        @(negedge clk); new_frame_in = 1'b1; set_rows(0); x_in = 100; y_in = 50;
        @(negedge clk); x_in = 400;
        @(negedge clk); new_frame_in = 1'b0; x_in = 100;
        run_pixel("hold_nf_old", 100, 50, 1, 24'h0, 1'b0);
        run_pixel("hold_nf_new", 400, 50, 1, COL, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
